load_store_unit: RTL
====================

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 Parameter: TIMEOUT, default 255, maximum REQ-state cycles without mem_ack before abort (1..255).
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  issue request from MEM stage; sampled only in IDLE.
REQ-005 is_store  input  1  1 = store, 0 = load.
REQ-006 funct3  input  3  RV32I width/sign code (LB 000, LH 001, LW 010, LBU 100, LHU 101; SB 000, SH 001, SW 010).
REQ-007 addr  input  32  byte address.
REQ-008 store_data  input  32  store source (rs2).
REQ-009 busy  output  1  stall to pipeline; 1 whenever state != IDLE.
REQ-010 done  output  1  one-cycle completion pulse.
REQ-011 load_data  output  32  formatted load result; feeds writeback mux memory input.
REQ-012 fault  output  2  00 none, 01 misaligned, 10 illegal funct3, 11 bus timeout; valid with done.
REQ-013 mem_req / mem_we  output  1 each  bus request / write enable.
REQ-014 mem_addr  output  32  word-aligned address ({addr[31:2],2'b00}).
REQ-015 mem_wdata  output  32  lane-replicated store data.
REQ-016 mem_be  output  4  byte enables.
REQ-017 mem_ack  input  1  bus completion, one cycle; mem_rdata  input  32  read data valid with mem_ack.

Function
REQ-018 FSM states SHALL be IDLE, REQ, DONE; busy = (state != IDLE).
REQ-019 IDLE with start=1: latch is_store, funct3, addr[1:0], mem_addr, mem_wdata, mem_be; check legality; next state REQ if legal, else DONE with fault set.
REQ-020 Illegal funct3: loads 011/110/111, stores 011..111 -> fault 10; illegal takes priority over misaligned.
REQ-021 Misaligned: halfword with addr[0]=1, word with addr[1:0]!=00 -> fault 01; no bus request issued.
REQ-022 REQ: mem_req=1, mem_we=is_store, address/data/be held stable until mem_ack or timeout.
REQ-023 REQ with mem_ack=1: capture and format mem_rdata (loads), next state DONE, fault 00.
REQ-024 Timeout counter cleared on entry to REQ, increments each REQ cycle without ack; at count = TIMEOUT -> DONE, fault 11, load_data 0; mem_ack in the same cycle as expiry wins (normal completion).
REQ-025 DONE: done=1 for exactly one cycle, mem_req=0, then IDLE; start in DONE is ignored.
REQ-026 start while busy SHALL be ignored (no queuing).
REQ-027 Latency: ack in first REQ cycle -> done asserted 2 cycles after start accepted; fault path -> done 1 cycle after start.
REQ-028 Store lanes: SB mem_be = 0001<<addr[1:0], wdata = byte x4; SH mem_be = 0011<<{addr[1],0}, wdata = half x2; SW mem_be = 1111.
REQ-029 Load format: select byte/half by latched addr[1:0]; LB/LH sign-extend, LBU/LHU zero-extend, LW pass-through.
REQ-030 load_data SHALL hold its value until the next done; stores and faults drive load_data 0 at done.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, busy 0, done 0, fault 00, load_data 0, mem_req 0, mem_we 0, mem_addr 0, mem_wdata 0, mem_be 0, counter 0.
REQ-032 Reset during REQ SHALL abandon the transaction with no done pulse; first start after rst_n rises is accepted normally.

Verification
REQ-033 LW addr 0x100, mem_ack on first REQ cycle, mem_rdata 0xDEADBEEF -> mem_addr 0x100, mem_be 1111, done 2 cycles after start, load_data 0xDEADBEEF, fault 00.
REQ-034 LB addr 0x103, mem_rdata 0x80112233 -> load_data 0xFFFFFF80; repeat as LBU -> 0x00000080.
REQ-035 SH addr 0x202, store_data 0x0000ABCD -> mem_addr 0x200, mem_be 1100, mem_wdata 0xABCDABCD, mem_we 1.
REQ-036 LW addr 0x101 -> mem_req never asserted, done 1 cycle after start, fault 01, load_data 0; funct3 011 load -> fault 10.
REQ-037 TIMEOUT=4, mem_ack held 0 -> 4 REQ cycles, then done with fault 11, mem_req deasserted; second start during busy ignored.
REQ-038 rst_n low mid-REQ -> mem_req 0 asynchronously, no done; after release LW addr 0x0 with ack -> completes normally.

Source files
------------

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Executes one RV32I load or store at a time on behalf of the MEM stage.
// An accepted request is checked for an illegal width code and for
// misalignment, then issued to a simple req/ack memory bus. Loaded data is
// aligned and sign/zero-extended. A missing ack is bounded by a timeout.
//
// Parameters
//   TIMEOUT    : REQ-state cycles without mem_ack before the request aborts (1..255)
// Ports
//   clk, rst_n : clock, asynchronous active-low reset
//   start      : request strobe, sampled only while idle
//   is_store   : 1 = store, 0 = load
//   funct3     : RV32I width/sign code
//   addr       : byte address
//   store_data : store source data (rs2)
//   busy       : pipeline stall, high whenever a request is in flight
//   done       : one-cycle completion pulse
//   load_data  : formatted load result, held until the next done
//   fault      : 00 none, 01 misaligned, 10 illegal funct3, 11 bus timeout
//   mem_req/we : bus request / write enable
//   mem_addr   : word-aligned bus address
//   mem_wdata  : lane-replicated store data
//   mem_be     : byte enables
//   mem_ack    : bus completion strobe
//   mem_rdata  : bus read data, valid with mem_ack
// -----------------------------------------------------------------------------
module load_store_unit #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        is_store,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        busy,
    output logic        done,
    output logic [31:0] load_data,
    output logic [1:0]  fault,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    logic        is_store_q;
    logic [2:0]  funct3_q;
    logic [1:0]  lane_q;
    logic [7:0]  count;

    logic        illegal;
    logic        misaligned;
    logic        count_last;
    logic [3:0]  be_new;
    logic [31:0] wdata_new;
    logic [7:0]  byte_sel;
    logic [15:0] half_sel;
    logic [31:0] fmt_data;

    // Decode of the incoming request. funct3[1:0] is the access width for
    // both loads and stores; illegal codes are reported ahead of misalignment.
    always_comb begin
        illegal    = 1'b0;
        misaligned = 1'b0;
        be_new     = 4'b1111;
        wdata_new  = store_data;
        if (is_store) begin
            illegal = funct3[2] | (funct3[1:0] == 2'b11);
        end else begin
            illegal = (funct3[1:0] == 2'b11) | (funct3 == 3'b110);
        end
        misaligned = ((funct3[1:0] == 2'b01) & addr[0]) |
                     ((funct3[1:0] == 2'b10) & (addr[1:0] != 2'b00));
        case (funct3[1:0])
            2'b00: begin
                be_new    = 4'b0001 << addr[1:0];
                wdata_new = {4{store_data[7:0]}};
            end
            2'b01: begin
                be_new    = 4'b0011 << {addr[1], 1'b0};
                wdata_new = {2{store_data[15:0]}};
            end
            default: begin
                be_new    = 4'b1111;
                wdata_new = store_data;
            end
        endcase
    end

    // Load alignment uses the lane captured when the request was accepted.
    always_comb begin
        byte_sel = mem_rdata[7:0];
        case (lane_q)
            2'd0:    byte_sel = mem_rdata[7:0];
            2'd1:    byte_sel = mem_rdata[15:8];
            2'd2:    byte_sel = mem_rdata[23:16];
            default: byte_sel = mem_rdata[31:24];
        endcase
        half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        case (funct3_q)
            3'b000:  fmt_data = {{24{byte_sel[7]}}, byte_sel};
            3'b100:  fmt_data = {24'd0, byte_sel};
            3'b001:  fmt_data = {{16{half_sel[15]}}, half_sel};
            3'b101:  fmt_data = {16'd0, half_sel};
            default: fmt_data = mem_rdata;
        endcase
    end

    // True in the REQ cycle that would bring the no-ack count up to TIMEOUT.
    assign count_last = (({1'b0, count} + 9'd1) == 9'(TIMEOUT));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE: begin
                if (start) begin
                    next_state = (illegal | misaligned) ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (mem_ack | count_last) begin
                    next_state = S_DONE;
                end
            end
            S_DONE:  next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
        busy    = (state != S_IDLE);
        done    = (state == S_DONE);
        mem_req = (state == S_REQ);
        mem_we  = (state == S_REQ) & is_store_q;
    end

    // Request capture, timeout counting and result registers. load_data and
    // fault only change on the edge that enters DONE, so they hold in between.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            is_store_q <= 1'b0;
            funct3_q   <= 3'd0;
            lane_q     <= 2'd0;
            count      <= 8'd0;
            mem_addr   <= 32'd0;
            mem_wdata  <= 32'd0;
            mem_be     <= 4'd0;
            load_data  <= 32'd0;
            fault      <= 2'b00;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        is_store_q <= is_store;
                        funct3_q   <= funct3;
                        lane_q     <= addr[1:0];
                        count      <= 8'd0;
                        mem_addr   <= {addr[31:2], 2'b00};
                        mem_wdata  <= wdata_new;
                        mem_be     <= be_new;
                        if (illegal) begin
                            fault     <= 2'b10;
                            load_data <= 32'd0;
                        end else if (misaligned) begin
                            fault     <= 2'b01;
                            load_data <= 32'd0;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack) begin
                        fault     <= 2'b00;
                        load_data <= is_store_q ? 32'd0 : fmt_data;
                    end else if (count_last) begin
                        fault     <= 2'b11;
                        load_data <= 32'd0;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
